// File: rtl/mux4_arbiter_if.sv
// Bundle of request, data, handshake and grant signals between four requesters,
// the downstream consumer and the mux4_arbiter.
interface mux4_arbiter_if;
  localparam int unsigned N  = 4;
  localparam int unsigned IW = 2;
  localparam int unsigned DW = 4;

  logic [N-1:0]  req;
  logic [DW-1:0] d0;
  logic [DW-1:0] d1;
  logic [DW-1:0] d2;
  logic [DW-1:0] d3;
  logic          ready;
  logic [N-1:0]  gnt;
  logic [IW-1:0] which;
  logic [DW-1:0] o;
  logic          valid;
  logic          busy;

  modport master (
    output req, d0, d1, d2, d3, ready,
    input  gnt, which, o, valid, busy
  );

  modport slave (
    input  req, d0, d1, d2, d3, ready,
    output gnt, which, o, valid, busy
  );
endinterface

// File: rtl/mux4_arbiter.sv
// Round-robin arbiter for a shared 4:1 datapath with bounded bursts and
// zero-bubble handover between requesters.
module mux4_arbiter #(
  parameter int unsigned MAX_BEATS = 4
) (
  input  logic           clk,
  input  logic           rst,
  mux4_arbiter_if.slave  bus
);
  localparam int unsigned N  = 4;
  localparam int unsigned IW = 2;
  localparam int unsigned CW = 4;
  localparam int unsigned DW = 4;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] which_q, which_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic          busy_q, busy_d;

  logic          xfer;
  logic          rel_a;
  logic          rel_b;
  logic [N-1:0]  rel_req;
  logic [IW:0]   idle_pick;
  logic [IW:0]   rel_pick;
  logic [IW-1:0] rel_ptr;

  // Returns {hit, index} of the first set bit scanning p, p+1, p+2, p+3 (mod 4).
  function automatic logic [IW:0] pick(input logic [N-1:0] r, input logic [IW-1:0] p);
    logic [IW-1:0] idx;
    logic [IW:0]   res;
    res = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = p + IW'(i);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      which_q <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      which_q <= which_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    which_d   = which_q;
    gnt_d     = gnt_q;
    busy_d    = busy_q;
    xfer      = (state_q == GRANT) && bus.req[which_q] && bus.ready;
    rel_a     = (state_q == GRANT) && !bus.req[which_q];
    rel_b     = xfer && ((cnt_q + CW'(1)) == CW'(MAX_BEATS));
    rel_ptr   = which_q + IW'(1);
    // A dropped owner is masked; an exhausted owner stays eligible at lowest priority.
    rel_req   = rel_a ? (bus.req & ~(N'(1) << which_q)) : bus.req;
    idle_pick = pick(bus.req, ptr_q);
    rel_pick  = pick(rel_req, rel_ptr);

    unique case (state_q)
      IDLE: begin
        if (idle_pick[IW]) begin
          which_d = idle_pick[IW-1:0];
          gnt_d   = N'(1) << idle_pick[IW-1:0];
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (rel_a || rel_b) begin
          ptr_d = rel_ptr;
          cnt_d = '0;
          if (rel_pick[IW]) begin
            which_d = rel_pick[IW-1:0];
            gnt_d   = N'(1) << rel_pick[IW-1:0];
            busy_d  = 1'b1;
          end else begin
            gnt_d   = '0;
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end else if (xfer) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  logic [DW-1:0] sel_data;

  always_comb begin
    sel_data = '0;
    unique case (which_q)
      2'd0: sel_data = bus.d0;
      2'd1: sel_data = bus.d1;
      2'd2: sel_data = bus.d2;
      2'd3: sel_data = bus.d3;
      default: sel_data = '0;
    endcase
  end

  assign bus.gnt   = gnt_q;
  assign bus.which = which_q;
  assign bus.busy  = busy_q;
  assign bus.valid = (state_q == GRANT) && bus.req[which_q];
  assign bus.o     = (state_q == GRANT) ? sel_data : '0;
endmodule

// File: tb/tb_mux4_arbiter.sv
// Directed bench for mux4_arbiter: three instances (MAX_BEATS 4, 2, 1) share one
// stimulus stream; each step checks the packed {gnt, which, busy, valid, o} view.
module tb_mux4_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] d0, d1, d2, d3;
  logic       ready;
  int         checks = 0;
  int         errors = 0;
  logic [3:0] dv [4];

  mux4_arbiter_if bus4 ();
  mux4_arbiter_if bus2 ();
  mux4_arbiter_if bus1 ();

  assign bus4.req = req; assign bus4.ready = ready;
  assign bus4.d0 = d0; assign bus4.d1 = d1; assign bus4.d2 = d2; assign bus4.d3 = d3;
  assign bus2.req = req; assign bus2.ready = ready;
  assign bus2.d0 = d0; assign bus2.d1 = d1; assign bus2.d2 = d2; assign bus2.d3 = d3;
  assign bus1.req = req; assign bus1.ready = ready;
  assign bus1.d0 = d0; assign bus1.d1 = d1; assign bus1.d2 = d2; assign bus1.d3 = d3;

  mux4_arbiter #(.MAX_BEATS(4)) u4 (.clk(clk), .rst(rst), .bus(bus4));
  mux4_arbiter #(.MAX_BEATS(2)) u2 (.clk(clk), .rst(rst), .bus(bus2));
  mux4_arbiter #(.MAX_BEATS(1)) u1 (.clk(clk), .rst(rst), .bus(bus1));

  always #5 clk = ~clk;

  logic [11:0] obs4, obs2, obs1;
  assign obs4 = {bus4.gnt, bus4.which, bus4.busy, bus4.valid, bus4.o};
  assign obs2 = {bus2.gnt, bus2.which, bus2.busy, bus2.valid, bus2.o};
  assign obs1 = {bus1.gnt, bus1.which, bus1.busy, bus1.valid, bus1.o};

  function automatic logic [11:0] pk(input logic [3:0] g, input logic [1:0] w,
                                     input logic b, input logic v, input logic [3:0] o);
    return {g, w, b, v, o};
  endfunction

  // Expected view of a busy, valid grant to requester w.
  function automatic logic [11:0] granted(input int w);
    logic [3:0] g;
    g = 4'(1) << w;
    return pk(g, 2'(w), 1'b1, 1'b1, dv[w]);
  endfunction

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    #1;
    rst = 1'b0;
  endtask

  int exp2 [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
  int exp1 [5] = '{0, 1, 2, 3, 0};

  initial begin
    d0 = 4'h3; d1 = 4'hA; d2 = 4'h5; d3 = 4'hC;
    dv[0] = 4'h3; dv[1] = 4'hA; dv[2] = 4'h5; dv[3] = 4'hC;
    rst = 1'b1; req = 4'b0000; ready = 1'b0;
    #1;
    chk("reset_u4", obs4, 12'h000);
    chk("reset_u2", obs2, 12'h000);
    chk("reset_u1", obs1, 12'h000);
    @(negedge clk);
    rst = 1'b0;

    // Single requester; re-granted in place after MAX_BEATS beats.
    req = 4'b0010; ready = 1'b1;
    tick();
    chk("single_grant", obs4, granted(1));
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("single_hold", obs4, granted(1));
    end

    // Asynchronous reset in the middle of a burst.
    pulse_rst();
    req = 4'b0100;
    tick();
    chk("pre_reset_grant", obs4, granted(2));
    #2 rst = 1'b1;
    #1;
    chk("async_reset_u4", obs4, 12'h000);
    chk("async_reset_u2", obs2, 12'h000);
    rst = 1'b0;
    req = 4'b0110;
    tick();
    chk("post_reset_lowest", obs4, granted(1));

    // Full contention: rotation every MAX_BEATS cycles.
    pulse_rst();
    req = 4'b1111; ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      tick();
      chk("contention_mb2", obs2, granted(exp2[k]));
      if (k < 5) chk("contention_mb1", obs1, granted(exp1[k]));
      if (k == 3) chk("contention_mb4_hold", obs4, granted(0));
      if (k == 4) chk("contention_mb4_rot", obs4, granted(1));
    end

    // Backpressure: cnt frozen during the stall, four beats then handover.
    pulse_rst();
    req = 4'b0011; ready = 1'b0;
    tick();
    chk("bp_grant", obs4, granted(0));
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_stall", obs4, granted(0));
    end
    ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_beats", obs4, granted(0));
    end
    tick();
    chk("bp_handover", obs4, granted(1));

    // Early release with no idle cycle.
    pulse_rst();
    req = 4'b0100; ready = 1'b1;
    tick();
    chk("early_owner2", obs4, granted(2));
    req = 4'b1111;
    tick();
    chk("early_beat1", obs4, granted(2));
    req = 4'b1011;
    tick();
    chk("early_to3", obs4, granted(3));
    req = 4'b0011;
    tick();
    chk("early_to0", obs4, granted(0));
    req = 4'b0010;
    tick();
    chk("early_to1", obs4, granted(1));

    // Drain to idle; which holds its last value.
    req = 4'b0000;
    tick();
    chk("drain_idle", obs4, pk(4'b0000, 2'd1, 1'b0, 1'b0, 4'h0));
    tick();
    chk("idle_stays", obs4, pk(4'b0000, 2'd1, 1'b0, 1'b0, 4'h0));
    req = 4'b0001;
    tick();
    chk("regrant_from_idle", obs4, granted(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
